cam_blob_decoder: RTL

CAM_BLOB_DECODER -- requirements
Module: cam_blob_decoder

---
 rtl/cam_blob_decoder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/cam_blob_decoder.sv
// cam_blob_decoder: assembles 3-byte camera blob packets into X/Y/size and flags lost blobs.
// Define CAM_BLOB_SMOOTH_EN to output the running mean of the last 4 valid X/Y samples.
module cam_blob_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       frame_start,
    output logic [9:0] x_out,
    output logic [9:0] y_out,
    output logic [3:0] size_out,
    output logic       valid_out,
    output logic       blob_present
);

    localparam int unsigned CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [9:0]  Y_MAX   = 10'd767;
    localparam logic [9:0]  NO_BLOB = 10'd1023;

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2,
        DONE
    } state_e;

    state_e        state_q;
    logic [7:0]    b0_q;
    logic [7:0]    b1_q;
    logic [CW-1:0] cnt_q;
    logic [9:0]    x_q;
    logic [9:0]    y_q;
    logic [3:0]    size_q;
    logic          valid_q;
    logic          present_q;

    logic          pkt_done_c;
    logic          blob_ok_c;
    logic          timeout_c;
    logic [9:0]    asm_x_c;
    logic [9:0]    asm_y_c;
    logic [9:0]    out_x_c;
    logic [9:0]    out_y_c;

    // A frame_start in the same cycle as byte2 restarts the packet instead of completing it.
    always_comb begin
        asm_x_c    = {byte_in[5:4], b0_q};
        asm_y_c    = {byte_in[7:6], b1_q};
        pkt_done_c = (state_q == WAIT_B2) && byte_valid && !frame_start;
        blob_ok_c  = (asm_y_c <= Y_MAX);
        timeout_c  = !pkt_done_c && present_q && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end

`ifdef CAM_BLOB_SMOOTH_EN
    // Three previous samples plus the incoming one form the 4-sample window.
    logic [9:0]  hx_q [3];
    logic [9:0]  hy_q [3];
    logic        hist_q;
    logic [11:0] sum_x_c;
    logic [11:0] sum_y_c;

    always_comb begin
        sum_x_c = {asm_x_c, 2'b00};
        sum_y_c = {asm_y_c, 2'b00};
        if (hist_q) begin
            sum_x_c = 12'(asm_x_c) + 12'(hx_q[0]) + 12'(hx_q[1]) + 12'(hx_q[2]);
            sum_y_c = 12'(asm_y_c) + 12'(hy_q[0]) + 12'(hy_q[1]) + 12'(hy_q[2]);
        end
        out_x_c = sum_x_c[11:2];
        out_y_c = sum_y_c[11:2];
    end

    // First sample after an empty history fills every slot with itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                hx_q[i] <= '0;
                hy_q[i] <= '0;
            end
        end else if (pkt_done_c && blob_ok_c) begin
            hist_q  <= 1'b1;
            hx_q[0] <= asm_x_c;
            hy_q[0] <= asm_y_c;
            hx_q[1] <= hist_q ? hx_q[0] : asm_x_c;
            hy_q[1] <= hist_q ? hy_q[0] : asm_y_c;
            hx_q[2] <= hist_q ? hx_q[1] : asm_x_c;
            hy_q[2] <= hist_q ? hy_q[1] : asm_y_c;
        end else if (pkt_done_c || timeout_c) begin
            hist_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                hx_q[i] <= '0;
                hy_q[i] <= '0;
            end
        end
    end
`else
    always_comb begin
        out_x_c = asm_x_c;
        out_y_c = asm_y_c;
    end
`endif

    // Packet FSM, output registers and loss timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= WAIT_B0;
            b0_q      <= '0;
            b1_q      <= '0;
            cnt_q     <= '0;
            x_q       <= NO_BLOB;
            y_q       <= NO_BLOB;
            size_q    <= '0;
            valid_q   <= 1'b0;
            present_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            if (frame_start) begin
                if (byte_valid) begin
                    b0_q    <= byte_in;
                    state_q <= WAIT_B1;
                end else begin
                    state_q <= WAIT_B0;
                end
            end else if (byte_valid) begin
                case (state_q)
                    WAIT_B0: begin
                        b0_q    <= byte_in;
                        state_q <= WAIT_B1;
                    end
                    WAIT_B1: begin
                        b1_q    <= byte_in;
                        state_q <= WAIT_B2;
                    end
                    WAIT_B2: state_q <= DONE;
                    default: state_q <= DONE;
                endcase
            end

            if (pkt_done_c || timeout_c) begin
                valid_q <= 1'b1;
                cnt_q   <= '0;
                if (pkt_done_c && blob_ok_c) begin
                    x_q       <= out_x_c;
                    y_q       <= out_y_c;
                    size_q    <= byte_in[3:0];
                    present_q <= 1'b1;
                end else begin
                    x_q       <= NO_BLOB;
                    y_q       <= NO_BLOB;
                    size_q    <= '0;
                    present_q <= 1'b0;
                end
            end else if (cnt_q != CW'(TIMEOUT_CYCLES)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign x_out        = x_q;
    assign y_out        = y_q;
    assign size_out     = size_q;
    assign valid_out    = valid_q;
    assign blob_present = present_q;

endmodule
